// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response handshake for two client ports plus the
// command/result bus toward the shared ALU.
interface alu_arbiter_if;
  logic [1:0]  I_req_valid;
  logic [4:0]  I_req_op0;
  logic [4:0]  I_req_op1;
  logic [31:0] I_req_a0;
  logic [31:0] I_req_b0;
  logic [31:0] I_req_a1;
  logic [31:0] I_req_b1;
  logic [1:0]  O_req_ready;
  logic [1:0]  O_rsp_valid;
  logic [31:0] O_rsp_data;
  logic        O_rsp_lt;
  logic        O_rsp_ltu;
  logic        O_rsp_eq;
  logic        O_rsp_err;
  logic        O_alu_en;
  logic [31:0] O_alu_dataS1;
  logic [31:0] O_alu_dataS2;
  logic [4:0]  O_alu_aluop;
  logic        O_alu_reset;
  logic        I_alu_busy;
  logic [31:0] I_alu_data;
  logic        I_alu_lt;
  logic        I_alu_ltu;
  logic        I_alu_eq;

  // Arbiter side.
  modport slave (
    input  I_req_valid, I_req_op0, I_req_op1,
    input  I_req_a0, I_req_b0, I_req_a1, I_req_b1,
    output O_req_ready, O_rsp_valid, O_rsp_data,
    output O_rsp_lt, O_rsp_ltu, O_rsp_eq, O_rsp_err,
    output O_alu_en, O_alu_dataS1, O_alu_dataS2, O_alu_aluop, O_alu_reset,
    input  I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq
  );

  // Environment side: both requesters and the ALU.
  modport master (
    output I_req_valid, I_req_op0, I_req_op1,
    output I_req_a0, I_req_b0, I_req_a1, I_req_b1,
    input  O_req_ready, O_rsp_valid, O_rsp_data,
    input  O_rsp_lt, O_rsp_ltu, O_rsp_eq, O_rsp_err,
    input  O_alu_en, O_alu_dataS1, O_alu_dataS2, O_alu_aluop, O_alu_reset,
    output I_alu_busy, I_alu_data, I_alu_lt, I_alu_ltu, I_alu_eq
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-port round-robin front end sharing one multi-cycle ALU.
// One transaction in flight at a time; a WAIT-state watchdog aborts and
// resets an ALU that never drops busy, answering with err=1.
module alu_arbiter #(
  parameter int WATCHDOG_CYCLES = 40
) (
  input logic          I_clk,
  input logic          I_reset_n,
  alu_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(WATCHDOG_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, ABORT, RESP} state_t;

  state_t             state;
  state_t             state_next;
  logic               grant;
  logic               grant_vld;
  logic               accept;
  logic               owner;
  logic               last_owner;
  logic [CNT_W-1:0]   wait_cnt;
  logic               watchdog_hit;
  logic [4:0]         op_q;
  logic [31:0]        a_q;
  logic [31:0]        b_q;
  logic [31:0]        rsp_data;
  logic               rsp_lt;
  logic               rsp_ltu;
  logic               rsp_eq;
  logic               rsp_err;

  // Round-robin pick: a lone requester wins, a tie goes to the port not served last.
  always_comb begin
    grant     = 1'b0;
    grant_vld = 1'b0;
    case (bus.I_req_valid)
      2'b01:   begin grant = 1'b0;        grant_vld = 1'b1; end
      2'b10:   begin grant = 1'b1;        grant_vld = 1'b1; end
      2'b11:   begin grant = ~last_owner; grant_vld = 1'b1; end
      default: begin grant = 1'b0;        grant_vld = 1'b0; end
    endcase
  end

  assign accept       = grant_vld && (state == IDLE) && I_reset_n;
  assign watchdog_hit = (wait_cnt == CNT_W'(WATCHDOG_CYCLES - 1));

  // State register.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) state <= IDLE;
    else            state <= state_next;
  end

  // Next-state logic; the watchdog fires on the last allowed busy WAIT cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT: begin
        if (!bus.I_alu_busy)  state_next = RESP;
        else if (watchdog_hit) state_next = ABORT;
      end
      ABORT:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state; ALU reset also follows the external reset combinationally.
  always_comb begin
    bus.O_req_ready = 2'b00;
    bus.O_rsp_valid = 2'b00;
    bus.O_alu_en    = 1'b0;
    bus.O_alu_reset = ~I_reset_n;
    case (state)
      IDLE:    if (grant_vld && I_reset_n) bus.O_req_ready[grant] = 1'b1;
      ISSUE:   bus.O_alu_en = 1'b1;
      WAIT:    bus.O_alu_en = bus.I_alu_busy;
      ABORT:   bus.O_alu_reset = 1'b1;
      RESP:    bus.O_rsp_valid[owner] = 1'b1;
      default: bus.O_alu_en = 1'b0;
    endcase
  end

  // Control and response registers: owner/pointer, watchdog counter, captured result.
  always_ff @(posedge I_clk) begin
    if (!I_reset_n) begin
      owner      <= 1'b0;
      last_owner <= 1'b1;
      wait_cnt   <= '0;
      rsp_data   <= '0;
      rsp_lt     <= 1'b0;
      rsp_ltu    <= 1'b0;
      rsp_eq     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_owner <= grant;
      end
      if (state == ISSUE)     wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (state == WAIT && !bus.I_alu_busy) begin
        rsp_data <= bus.I_alu_data;
        rsp_lt   <= bus.I_alu_lt;
        rsp_ltu  <= bus.I_alu_ltu;
        rsp_eq   <= bus.I_alu_eq;
        rsp_err  <= 1'b0;
      end
      if (state == ABORT) begin
        rsp_data <= '0;
        rsp_lt   <= 1'b0;
        rsp_ltu  <= 1'b0;
        rsp_eq   <= 1'b0;
        rsp_err  <= 1'b1;
      end
    end
  end

  // Command latch: only written on accept, so the ALU bus never sees the other port.
  always_ff @(posedge I_clk) begin
    if (accept) begin
      op_q <= grant ? bus.I_req_op1 : bus.I_req_op0;
      a_q  <= grant ? bus.I_req_a1  : bus.I_req_a0;
      b_q  <= grant ? bus.I_req_b1  : bus.I_req_b0;
    end
  end

  assign bus.O_alu_dataS1 = a_q;
  assign bus.O_alu_dataS2 = b_q;
  assign bus.O_alu_aluop  = op_q;
  assign bus.O_rsp_data   = rsp_data;
  assign bus.O_rsp_lt     = rsp_lt;
  assign bus.O_rsp_ltu    = rsp_ltu;
  assign bus.O_rsp_eq     = rsp_eq;
  assign bus.O_rsp_err    = rsp_err;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and random requests on both ports against a stub
// multi-cycle ALU; expected responses are queued at grant time and checked
// by an independent monitor.
module tb_alu_arbiter;

  localparam int WD = 40;
  // Opcode values only matter to the stub ALU below.
  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_SLT = 5'd2, OP_SLTU = 5'd3,
                         OP_AND = 5'd4, OP_OR = 5'd5, OP_XOR = 5'd6, OP_SLL = 5'd7,
                         OP_SRL = 5'd8, OP_SRA = 5'd9;

  typedef struct {
    int          port;
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        lt;
    logic        ltu;
    logic        eq;
    logic        err;
    int          due;
    int          en_cycles;
    int          rst_pulses;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  alu_arbiter_if bus();

  alu_arbiter #(.WATCHDOG_CYCLES(WD)) dut (
    .I_clk    (clk),
    .I_reset_n(reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  logic [1:0]  vld;
  logic [4:0]  op_in [2];
  logic [31:0] a_in  [2];
  logic [31:0] b_in  [2];
  assign bus.I_req_valid = vld;
  assign bus.I_req_op0   = op_in[0];
  assign bus.I_req_op1   = op_in[1];
  assign bus.I_req_a0    = a_in[0];
  assign bus.I_req_b0    = b_in[0];
  assign bus.I_req_a1    = a_in[1];
  assign bus.I_req_b1    = b_in[1];

  int   edge_cnt = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_port = 1;
  int   free_at = 0;
  bit   pend [2];
  bit   taken [2];
  bit   staged [2];
  logic [4:0]  st_op [2];
  logic [31:0] st_a [2];
  logic [31:0] st_b [2];
  bit   stuck_mode = 1'b0;
  exp_t sb [$];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_SLT:  return {31'b0, ($signed(a) < $signed(b))};
      OP_SLTU: return {31'b0, (a < b)};
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_SLL:  return a << b[4:0];
      OP_SRL:  return a >> b[4:0];
      OP_SRA:  return $unsigned($signed(a) >>> b[4:0]);
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit is_shift(input logic [4:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

  // Stub ALU: shifts stay busy for amount+1 cycles; stuck mode never drops busy.
  logic        running;
  logic        stuck_on;
  int          busy_cnt;
  logic [31:0] alu_res;
  logic        r_lt, r_ltu, r_eq;
  always @(posedge clk) begin
    if (bus.O_alu_reset) begin
      running  <= 1'b0;
      stuck_on <= 1'b0;
      busy_cnt <= 0;
    end else if (bus.O_alu_en && !running) begin
      running  <= 1'b1;
      stuck_on <= stuck_mode;
      alu_res  <= ref_result(bus.O_alu_aluop, bus.O_alu_dataS1, bus.O_alu_dataS2);
      r_lt     <= $signed(bus.O_alu_dataS1) < $signed(bus.O_alu_dataS2);
      r_ltu    <= bus.O_alu_dataS1 < bus.O_alu_dataS2;
      r_eq     <= bus.O_alu_dataS1 == bus.O_alu_dataS2;
      busy_cnt <= is_shift(bus.O_alu_aluop) ? int'(bus.O_alu_dataS2[4:0]) + 1 : 0;
    end else if (running) begin
      if (busy_cnt != 0)  busy_cnt <= busy_cnt - 1;
      else if (!stuck_on) running  <= 1'b0;
    end
  end
  assign bus.I_alu_busy = running && ((busy_cnt != 0) || stuck_on);
  assign bus.I_alu_data = alu_res;
  assign bus.I_alu_lt   = r_lt;
  assign bus.I_alu_ltu  = r_ltu;
  assign bus.I_alu_eq   = r_eq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  task automatic stage(input int p, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    staged[p] = 1'b1;
    st_op[p]  = op;
    st_a[p]   = a;
    st_b[p]   = b;
  endtask

  // One cycle of stimulus: drive at negedge, check ready, predict the grant.
  task automatic step(input bit allow_new);
    exp_t        e;
    int          g;
    int          nxt;
    int          k;
    int          lat;
    logic [1:0]  exp_ready;
    @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      if (taken[p]) begin
        vld[p]   = 1'b0;
        taken[p] = 1'b0;
      end
      if (staged[p]) begin
        vld[p] = 1'b1; op_in[p] = st_op[p]; a_in[p] = st_a[p]; b_in[p] = st_b[p];
        pend[p] = 1'b1; staged[p] = 1'b0;
      end else if (allow_new && !pend[p] && $urandom_range(0, 3) == 0) begin
        vld[p]   = 1'b1;
        op_in[p] = 5'($urandom_range(0, 9));
        a_in[p]  = $urandom;
        case ($urandom_range(0, 3))
          0:       b_in[p] = a_in[p];
          1:       b_in[p] = 32'($urandom_range(0, 40));
          default: b_in[p] = $urandom;
        endcase
        pend[p] = 1'b1;
      end
    end
    #1;
    nxt = edge_cnt + 1;
    g   = -1;
    if (nxt >= free_at && vld != 2'b00)
      g = (vld == 2'b11) ? 1 - last_port : (vld[0] ? 0 : 1);
    exp_ready = 2'b00;
    if (g >= 0) exp_ready[g] = 1'b1;
    chk("req_ready", 32'(bus.O_req_ready), 32'(exp_ready));
    if (g >= 0) begin
      k      = int'(b_in[g][4:0]);
      e.port = g;
      e.op   = op_in[g];
      e.a    = a_in[g];
      e.b    = b_in[g];
      if (stuck_mode) begin
        e.data = 32'h0; e.lt = 1'b0; e.ltu = 1'b0; e.eq = 1'b0; e.err = 1'b1;
        lat = WD + 3; e.en_cycles = WD + 1; e.rst_pulses = 1;
      end else begin
        e.data = ref_result(op_in[g], a_in[g], b_in[g]);
        e.lt   = $signed(a_in[g]) < $signed(b_in[g]);
        e.ltu  = a_in[g] < b_in[g];
        e.eq   = a_in[g] == b_in[g];
        e.err  = 1'b0;
        lat          = is_shift(op_in[g]) ? 4 + k : 3;
        e.en_cycles  = is_shift(op_in[g]) ? k + 2 : 1;
        e.rst_pulses = 0;
      end
      e.due = nxt + lat - 1;
      sb.push_back(e);
      last_port = g;
      free_at   = nxt + lat + 1;
      pend[g]   = 1'b0;
      taken[g]  = 1'b1;
    end
    @(posedge clk);
  endtask

  task automatic drain();
    int guard = 0;
    while ((sb.size() != 0 || pend[0] || pend[1] || staged[0] || staged[1]) && guard < 300) begin
      step(1'b0);
      guard++;
    end
    chk("drain_bound", 32'(guard < 300), 32'd1);
  endtask

  task automatic wait_taken(input int p);
    int guard = 0;
    while ((pend[p] || staged[p]) && guard < 100) begin
      step(1'b0);
      guard++;
    end
    chk("grant_bound", 32'(guard < 100), 32'd1);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    reset_n = 1'b0;
    vld     = 2'b11;
    #1;
    chk("alu_reset_comb", 32'(bus.O_alu_reset), 32'd1);
    repeat (cycles) begin
      @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.O_req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.O_rsp_valid), 32'd0);
      chk("rst_alu_en",    32'(bus.O_alu_en),    32'd0);
      chk("rst_alu_reset", 32'(bus.O_alu_reset), 32'd1);
    end
    sb.delete();
    for (int p = 0; p < 2; p++) begin
      pend[p] = 1'b0; taken[p] = 1'b0; staged[p] = 1'b0;
    end
    vld       = 2'b00;
    last_port = 1;
    free_at   = edge_cnt + 1;
    reset_n   = 1'b1;
  endtask

  // Monitor: pops the scoreboard on each response and watches the ALU command bus.
  int          en_cnt = 0;
  int          rst_cnt = 0;
  logic [31:0] last_data = 32'h0;
  logic        last_err = 1'b0;
  always begin
    exp_t f;
    @(negedge clk);
    #2;
    if (!reset_n) begin
      en_cnt = 0; rst_cnt = 0; last_data = 32'h0; last_err = 1'b0;
    end else begin
      if (bus.O_alu_en) begin
        en_cnt++;
        if (sb.size() == 0) chk("alu_en_spurious", 32'(bus.O_alu_en), 32'd0);
        else begin
          chk("alu_s1", bus.O_alu_dataS1, sb[0].a);
          chk("alu_s2", bus.O_alu_dataS2, sb[0].b);
          chk("alu_op", 32'(bus.O_alu_aluop), 32'(sb[0].op));
        end
      end
      if (bus.O_alu_reset) rst_cnt++;
      if (bus.O_rsp_valid != 2'b00) begin
        if (sb.size() == 0) chk("rsp_spurious", 32'(bus.O_rsp_valid), 32'd0);
        else begin
          f = sb.pop_front();
          chk("rsp_valid",   32'(bus.O_rsp_valid), 32'(2'b01 << f.port));
          chk("rsp_latency", 32'(edge_cnt),        32'(f.due));
          chk("rsp_data",    bus.O_rsp_data,       f.data);
          chk("rsp_lt",      32'(bus.O_rsp_lt),    32'(f.lt));
          chk("rsp_ltu",     32'(bus.O_rsp_ltu),   32'(f.ltu));
          chk("rsp_eq",      32'(bus.O_rsp_eq),    32'(f.eq));
          chk("rsp_err",     32'(bus.O_rsp_err),   32'(f.err));
          chk("alu_en_cycles", 32'(en_cnt),        32'(f.en_cycles));
          chk("alu_reset_pulses", 32'(rst_cnt),    32'(f.rst_pulses));
          last_data = f.data;
          last_err  = f.err;
        end
        en_cnt  = 0;
        rst_cnt = 0;
      end else begin
        chk("rsp_hold_data", bus.O_rsp_data,      last_data);
        chk("rsp_hold_err",  32'(bus.O_rsp_err),  32'(last_err));
        if (sb.size() != 0 && edge_cnt > sb[0].due) begin
          chk("rsp_timeout", 32'(edge_cnt), 32'(sb[0].due));
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0;
    vld     = 2'b11;
    for (int p = 0; p < 2; p++) begin
      op_in[p] = 5'd0; a_in[p] = 32'h0; b_in[p] = 32'h0;
    end
    do_reset(3);

    // Lone port 0 ADD.
    stage(0, OP_ADD, 32'd5, 32'd7);
    drain();

    // Simultaneous pair, then port 0 re-requests so port 1 wins the next tie.
    stage(0, OP_SUB, 32'd3, 32'd5);
    stage(1, OP_SLTU, 32'd3, 32'd5);
    wait_taken(0);
    stage(0, OP_ADD, 32'd9, 32'd1);
    drain();

    // Port 1 shift by 4.
    stage(1, OP_SLL, 32'd1, 32'd4);
    drain();

    // Hung ALU hits the watchdog, then a normal request.
    stuck_mode = 1'b1;
    stage(0, OP_ADD, 32'd2, 32'd3);
    drain();
    stuck_mode = 1'b0;
    stage(1, OP_XOR, 32'hF0F0_0000, 32'h0F0F_0000);
    drain();

    // Reset in the middle of a long shift, then ADD 1+1.
    stage(0, OP_SLL, 32'd3, 32'd20);
    wait_taken(0);
    repeat (5) step(1'b0);
    do_reset(2);
    stage(0, OP_ADD, 32'd1, 32'd1);
    drain();

    // Random traffic on both ports.
    repeat (400) step(1'b1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter WATCHDOG_CYCLES, default 40, max WAIT-state cycles before a transaction is aborted.
REQ-002 SHALL have: I_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have: I_reset_n  in  1  synchronous active-low reset.
REQ-004 SHALL have: I_req_valid  in  2  per-port request valid (bit i = port i).
REQ-005 SHALL have: I_req_op0, I_req_op1  in  5 each  ALU opcode (`ALUOP_* from aludefs.vh).
REQ-006 SHALL have: I_req_a0, I_req_b0, I_req_a1, I_req_b1  in  32 each  operands.
REQ-007 SHALL have: O_req_ready  out  2  per-port accept; handshake when valid&ready high at an edge.
REQ-008 SHALL have: O_rsp_valid  out  2  one-cycle response pulse to the owning port.
REQ-009 SHALL have: O_rsp_data  out  32; O_rsp_lt, O_rsp_ltu, O_rsp_eq  out  1 each; O_rsp_err  out  1; all shared, qualified by O_rsp_valid.
REQ-010 SHALL have: O_alu_en  out  1; O_alu_dataS1, O_alu_dataS2  out  32; O_alu_aluop  out  5; O_alu_reset  out  1 (active-high).
REQ-011 SHALL have: I_alu_busy  in  1; I_alu_data  in  32; I_alu_lt, I_alu_ltu, I_alu_eq  in  1 each.

Function
REQ-012 SHALL implement states IDLE, ISSUE, WAIT, ABORT, RESP.
REQ-013 IDLE: grant combinational; one valid port -> that port; both valid -> port not served last (round-robin pointer); O_req_ready = grant & (state==IDLE); none valid -> ready 0.
REQ-014 On handshake: latch op, operands, owner id; toggle-free pointer update = owner; go to ISSUE; at most one accept per edge.
REQ-015 O_alu_dataS1/S2/aluop SHALL drive latched values from ISSUE through WAIT, stable, no glitch to other port's data.
REQ-016 ISSUE: O_alu_en=1 for exactly one cycle, then WAIT.
REQ-017 WAIT: O_alu_en = I_alu_busy; if I_alu_busy=0, capture I_alu_data/lt/ltu/eq into response regs, go RESP (en must be 0 that cycle so ALU does not restart a shift).
REQ-018 WAIT cycle counter SHALL reset on entry; if counter reaches WATCHDOG_CYCLES with I_alu_busy=1, go ABORT.
REQ-019 ABORT: O_alu_reset=1, O_alu_en=0 for one cycle; response data 0, flags 0, err=1; go RESP.
REQ-020 RESP: O_rsp_valid[owner]=1 for one cycle, other bit 0; O_rsp_err=0 unless from ABORT; return IDLE; new request accepted no earlier than next IDLE cycle.
REQ-021 Latency: handshake at edge N -> O_rsp_valid high in cycle N+3 for non-shift ops; N+4+k for shift amount k (ALU busy for k+1 cycles).
REQ-022 Requests held across non-granted cycles SHALL be granted no later than after one transaction of the other port (no starvation).
REQ-023 O_rsp_* SHALL hold last values outside RESP; only O_rsp_valid qualifies them.

Reset
REQ-024 I_reset_n low at an edge SHALL force IDLE, pointer preferring port 0, counter 0, O_rsp_valid=0, O_req_ready=0 during reset, O_alu_en=0, response regs 0, O_rsp_err=0.
REQ-025 O_alu_reset SHALL be 1 while I_reset_n low (combinational) and in ABORT; reset mid-transaction SHALL drop it with no response pulse.

Verification
REQ-026 Port0 ADD a=5 b=7 alone -> ready0 at handshake, O_alu_en one cycle, rsp_valid=2'b01 three cycles later, data=12, err=0.
REQ-027 Both ports valid in same IDLE cycle, port0 SUB 3-5, port1 SLTU 3<5 -> port0 served first (data 0xFFFFFFFE, ltu=1), then port1 (data 1); next simultaneous pair -> port1 first.
REQ-028 Port1 SLL a=1 b=4 -> O_alu_en high ISSUE plus 5 busy cycles, low on busy drop; rsp_valid=2'b10 at N+8, data=0x10.
REQ-029 Stub ALU holds busy=1 forever -> after 40 WAIT cycles ABORT: O_alu_reset pulse, rsp_valid with err=1, data=0; next request completes normally.
REQ-030 I_reset_n low during WAIT of a shift -> next cycle IDLE, O_alu_en=0, O_alu_reset=1, no rsp_valid; after release a port0 ADD 1+1 returns 2.
